// File: rtl/penta_code_lock.sv
// Keypad code lock fed by one-hot debounced button pulses: entry, timed unlock, alarm lockout.
// Optional inactivity abort of partial entries when PENTA_LOCK_TIMEOUT_EN is defined.
module penta_code_lock #(
  parameter int          CODE_LEN       = 4,
  parameter logic [23:0] CODE           = 24'h000819,
  parameter int          MAX_TRIES      = 3,
  parameter int          OPEN_CYCLES    = 50_000_000,
  parameter int          LOCKOUT_CYCLES = 250_000_000,
  parameter int          TIMEOUT_CYCLES = 100_000_000
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       X0_deb,
  input  logic       X1_deb,
  input  logic       X2_deb,
  input  logic       X3_deb,
  input  logic       X4_deb,
  output logic       unlocked,
  output logic       alarm,
  output logic       err_pulse,
  output logic [2:0] digit_cnt,
  output logic [2:0] fail_cnt
);

  localparam int MAX_OL  = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int MAX_CYC = (MAX_OL > TIMEOUT_CYCLES) ? MAX_OL : TIMEOUT_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0] T_ONE      = TW'(1);
  localparam logic [TW-1:0] OPEN_LAST  = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCKOUT_CYCLES - 1);
`ifdef PENTA_LOCK_TIMEOUT_EN
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
`endif
  localparam logic [2:0]    LAST_DIGIT = 3'(CODE_LEN - 1);
  localparam logic [2:0]    LAST_TRY   = 3'(MAX_TRIES - 1);
  localparam logic [2:0]    TRIES      = 3'(MAX_TRIES);

  typedef enum logic [1:0] {S_ENTRY, S_OPEN, S_LOCKOUT} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      digit_cnt_q, digit_cnt_d;
  logic [2:0]      fail_cnt_q, fail_cnt_d;
  logic            mismatch_q, mismatch_d;
  logic            unlocked_q, unlocked_d;
  logic            alarm_q, alarm_d;
  logic            err_q, err_d;

  logic [4:0]      btn;
  logic            press;
  logic            multi;
  logic [2:0]      digit;
  logic [2:0]      exp_digit;
  logic            dig_bad;

  always_comb begin
    btn       = {X4_deb, X3_deb, X2_deb, X1_deb, X0_deb};
    press     = |btn;
    // More than one bit set: still one digit, but never a match.
    multi     = (btn & (btn - 5'd1)) != 5'd0;
    digit     = 3'd0;
    case (btn)
      5'b00010: digit = 3'd1;
      5'b00100: digit = 3'd2;
      5'b01000: digit = 3'd3;
      5'b10000: digit = 3'd4;
      default:  digit = 3'd0;
    endcase
    exp_digit = CODE[5'(digit_cnt_q) * 5'd3 +: 3];
    dig_bad   = multi || (digit != exp_digit);
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    digit_cnt_d = digit_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    mismatch_d  = mismatch_q;
    err_d       = 1'b0;

    case (state_q)
      S_ENTRY: begin
        if (press) begin
          timer_d = '0;
          if (digit_cnt_q == LAST_DIGIT) begin
            digit_cnt_d = 3'd0;
            mismatch_d  = 1'b0;
            if (!(mismatch_q || dig_bad)) begin
              state_d    = S_OPEN;
              fail_cnt_d = 3'd0;
            end else if (fail_cnt_q >= LAST_TRY) begin
              state_d    = S_LOCKOUT;
              fail_cnt_d = TRIES;
              err_d      = 1'b1;
            end else begin
              fail_cnt_d = fail_cnt_q + 3'd1;
              err_d      = 1'b1;
            end
          end else begin
            digit_cnt_d = digit_cnt_q + 3'd1;
            mismatch_d  = mismatch_q | dig_bad;
          end
        end
`ifdef PENTA_LOCK_TIMEOUT_EN
        else if (digit_cnt_q != 3'd0) begin
          if (timer_q == TO_LAST) begin
            timer_d     = '0;
            digit_cnt_d = 3'd0;
            mismatch_d  = 1'b0;
          end else begin
            timer_d = timer_q + T_ONE;
          end
        end
`endif
      end
      S_OPEN: begin
        // A press here only relocks; it is not the first digit of a new attempt.
        if (press || timer_q == OPEN_LAST) begin
          state_d = S_ENTRY;
          timer_d = '0;
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      S_LOCKOUT: begin
        if (timer_q == LOCK_LAST) begin
          state_d     = S_ENTRY;
          timer_d     = '0;
          fail_cnt_d  = 3'd0;
          digit_cnt_d = 3'd0;
          mismatch_d  = 1'b0;
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      default: begin
        state_d = S_ENTRY;
        timer_d = '0;
      end
    endcase

    unlocked_d = (state_d == S_OPEN);
    alarm_d    = (state_d == S_LOCKOUT);
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q     <= S_ENTRY;
      timer_q     <= '0;
      digit_cnt_q <= 3'd0;
      fail_cnt_q  <= 3'd0;
      mismatch_q  <= 1'b0;
      unlocked_q  <= 1'b0;
      alarm_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      digit_cnt_q <= digit_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      mismatch_q  <= mismatch_d;
      unlocked_q  <= unlocked_d;
      alarm_q     <= alarm_d;
      err_q       <= err_d;
    end
  end

  assign unlocked  = unlocked_q;
  assign alarm     = alarm_q;
  assign err_pulse = err_q;
  assign digit_cnt = digit_cnt_q;
  assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_penta_code_lock.sv
// Directed bench for penta_code_lock with short timers; timeout scenario follows PENTA_LOCK_TIMEOUT_EN.
module tb_penta_code_lock;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b0;
  logic [4:0] x      = 5'd0;
  logic       unlocked, alarm, err_pulse;
  logic [2:0] digit_cnt, fail_cnt;

  int total  = 0;
  int passed = 0;

  penta_code_lock #(
    .OPEN_CYCLES(8),
    .LOCKOUT_CYCLES(16),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .sysclk(sysclk),
    .reset(reset),
    .X0_deb(x[0]),
    .X1_deb(x[1]),
    .X2_deb(x[2]),
    .X3_deb(x[3]),
    .X4_deb(x[4]),
    .unlocked(unlocked),
    .alarm(alarm),
    .err_pulse(err_pulse),
    .digit_cnt(digit_cnt),
    .fail_cnt(fail_cnt)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Each press occupies exactly one rising edge; called and returns at a falling edge.
  task automatic press(input logic [4:0] m);
    x = m;
    @(negedge sysclk);
    x = 5'd0;
  endtask

  task automatic code4(input int a, input int b, input int c, input int d);
    press(5'(1 << a));
    press(5'(1 << b));
    press(5'(1 << c));
    press(5'(1 << d));
  endtask

  task automatic do_reset;
    @(negedge sysclk);
    reset = 1'b1;
    @(negedge sysclk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    #1;
    total++; if ({unlocked, alarm, err_pulse} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {unlocked, alarm, err_pulse}); else passed++;
    total++; if ({digit_cnt, fail_cnt} !== 6'd0) $display("FAIL reset_counts got=%0d/%0d exp=0/0", digit_cnt, fail_cnt); else passed++;
    @(negedge sysclk);
    reset = 1'b0;
    @(negedge sysclk);
    total++; if ({unlocked, alarm, err_pulse, digit_cnt, fail_cnt} !== 9'd0) $display("FAIL reset_idle got=%b exp=0", {unlocked, alarm, err_pulse, digit_cnt, fail_cnt}); else passed++;
  endtask

  task automatic test_correct;
    int n;
    do_reset;
    press(5'b00010);
    press(5'b01000);
    total++; if (digit_cnt !== 3'd2) $display("FAIL correct_partial_digits got=%0d exp=2", digit_cnt); else passed++;
    total++; if (unlocked !== 1'b0) $display("FAIL correct_partial_locked got=%b exp=0", unlocked); else passed++;
    press(5'b00001);
    press(5'b10000);
    total++; if (unlocked !== 1'b1) $display("FAIL correct_unlocked got=%b exp=1", unlocked); else passed++;
    total++; if ({digit_cnt, fail_cnt, err_pulse} !== 7'd0) $display("FAIL correct_counts got=%b exp=0", {digit_cnt, fail_cnt, err_pulse}); else passed++;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge sysclk);
      if (unlocked) n++;
      else break;
    end
    total++; if (n !== 8) $display("FAIL correct_open_len got=%0d exp=8", n); else passed++;
    total++; if (fail_cnt !== 3'd0) $display("FAIL correct_fail_after got=%0d exp=0", fail_cnt); else passed++;
  endtask

  task automatic test_wrong_then_right;
    do_reset;
    code4(1, 3, 0, 3);
    total++; if (err_pulse !== 1'b1) $display("FAIL wrong_err got=%b exp=1", err_pulse); else passed++;
    total++; if (fail_cnt !== 3'd1) $display("FAIL wrong_fail got=%0d exp=1", fail_cnt); else passed++;
    total++; if ({digit_cnt, unlocked, alarm} !== 5'd0) $display("FAIL wrong_state got=%b exp=0", {digit_cnt, unlocked, alarm}); else passed++;
    @(negedge sysclk);
    total++; if (err_pulse !== 1'b0) $display("FAIL wrong_err_width got=%b exp=0", err_pulse); else passed++;
    code4(1, 3, 0, 4);
    total++; if (unlocked !== 1'b1) $display("FAIL right_unlocked got=%b exp=1", unlocked); else passed++;
    total++; if (fail_cnt !== 3'd0) $display("FAIL right_fail_clear got=%0d exp=0", fail_cnt); else passed++;
  endtask

  task automatic test_lockout;
    int errs;
    int n;
    do_reset;
    errs = 0;
    for (int k = 0; k < 3; k++) begin
      code4(1, 3, 0, 3);
      if (err_pulse === 1'b1) errs++;
    end
    total++; if (errs !== 3) $display("FAIL lock_err_count got=%0d exp=3", errs); else passed++;
    total++; if (alarm !== 1'b1) $display("FAIL lock_alarm got=%b exp=1", alarm); else passed++;
    total++; if (fail_cnt !== 3'd3) $display("FAIL lock_fail got=%0d exp=3", fail_cnt); else passed++;
    code4(1, 3, 0, 4);
    total++; if (unlocked !== 1'b0) $display("FAIL lock_ignore_unlock got=%b exp=0", unlocked); else passed++;
    total++; if (digit_cnt !== 3'd0) $display("FAIL lock_ignore_digits got=%0d exp=0", digit_cnt); else passed++;
    n = 5;
    for (int i = 0; i < 40; i++) begin
      @(negedge sysclk);
      if (alarm) n++;
      else break;
    end
    total++; if (n !== 16) $display("FAIL lock_alarm_len got=%0d exp=16", n); else passed++;
    total++; if ({fail_cnt, digit_cnt} !== 6'd0) $display("FAIL lock_exit_counts got=%0d/%0d exp=0/0", fail_cnt, digit_cnt); else passed++;
    code4(1, 3, 0, 4);
    total++; if (unlocked !== 1'b1) $display("FAIL lock_then_open got=%b exp=1", unlocked); else passed++;
  endtask

  task automatic test_simultaneous;
    do_reset;
    press(5'b00110);
    total++; if (digit_cnt !== 3'd1) $display("FAIL simul_counts_one got=%0d exp=1", digit_cnt); else passed++;
    press(5'b01000);
    press(5'b00001);
    press(5'b10000);
    total++; if (err_pulse !== 1'b1) $display("FAIL simul_err got=%b exp=1", err_pulse); else passed++;
    total++; if (fail_cnt !== 3'd1) $display("FAIL simul_fail got=%0d exp=1", fail_cnt); else passed++;
    total++; if (unlocked !== 1'b0) $display("FAIL simul_locked got=%b exp=0", unlocked); else passed++;
  endtask

  task automatic test_relock_reset;
    do_reset;
    code4(1, 3, 0, 4);
    repeat (2) @(negedge sysclk);
    total++; if (unlocked !== 1'b1) $display("FAIL relock_before got=%b exp=1", unlocked); else passed++;
    press(5'b00100);
    total++; if (unlocked !== 1'b0) $display("FAIL relock_unlocked got=%b exp=0", unlocked); else passed++;
    total++; if (digit_cnt !== 3'd0) $display("FAIL relock_discard got=%0d exp=0", digit_cnt); else passed++;
    code4(1, 3, 0, 4);
    total++; if (unlocked !== 1'b1) $display("FAIL relock_reopen got=%b exp=1", unlocked); else passed++;
    do_reset;
    code4(1, 3, 0, 3);
    press(5'b00010);
    press(5'b01000);
    total++; if ({digit_cnt, fail_cnt} !== {3'd2, 3'd1}) $display("FAIL midreset_pre got=%0d/%0d exp=2/1", digit_cnt, fail_cnt); else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if ({unlocked, alarm, err_pulse, digit_cnt, fail_cnt} !== 9'd0) $display("FAIL midreset_async got=%b exp=0", {unlocked, alarm, err_pulse, digit_cnt, fail_cnt}); else passed++;
    @(negedge sysclk);
    reset = 1'b0;
  endtask

  task automatic test_timeout;
    int errs;
    do_reset;
    press(5'b00010);
    press(5'b01000);
    errs = 0;
`ifdef PENTA_LOCK_TIMEOUT_EN
    for (int i = 0; i < 9; i++) begin
      @(negedge sysclk);
      if (err_pulse === 1'b1) errs++;
    end
    total++; if (digit_cnt !== 3'd2) $display("FAIL timeout_held got=%0d exp=2", digit_cnt); else passed++;
    @(negedge sysclk);
    if (err_pulse === 1'b1) errs++;
    total++; if (digit_cnt !== 3'd0) $display("FAIL timeout_abort got=%0d exp=0", digit_cnt); else passed++;
    total++; if ({errs, fail_cnt} !== {32'd0, 3'd0}) $display("FAIL timeout_no_fail got=%0d/%0d exp=0/0", errs, fail_cnt); else passed++;
    code4(1, 3, 0, 4);
    total++; if (unlocked !== 1'b1) $display("FAIL timeout_then_open got=%b exp=1", unlocked); else passed++;
`else
    for (int i = 0; i < 30; i++) begin
      @(negedge sysclk);
      if (err_pulse === 1'b1) errs++;
    end
    total++; if (digit_cnt !== 3'd2) $display("FAIL hold_partial got=%0d exp=2", digit_cnt); else passed++;
    total++; if (errs !== 0) $display("FAIL hold_no_err got=%0d exp=0", errs); else passed++;
    press(5'b00001);
    press(5'b10000);
    total++; if (unlocked !== 1'b1) $display("FAIL hold_then_open got=%b exp=1", unlocked); else passed++;
`endif
  endtask

  initial begin
    test_reset;
    test_correct;
    test_wrong_then_right;
    test_lockout;
    test_simultaneous;
    test_relock_reset;
    test_timeout;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
